// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a small single-cycle core. Each cycle in RUN
// the PC advances: pc+1, a taken branch (pc+1+imm), an absolute jump (imm), or
// a register jump (reg_target, or the top of the return-address stack when
// that is built in). A HALT instruction parks the core until reset. A
// switch-input instruction parks it in WAIT_CONFIRM until a rising edge on the
// debounced confirm button, and then steps to pc+1.
//
// Optional feature macro: PC_SEQ_RAS_EN
//   Defined   : circular return-address stack of RAS_DEPTH x PC_WIDTH.
//               jal pushes pc+1, and jr pops its target from the stack.
//   Undefined : jr always uses reg_target. The ras_* outputs are tied to 0.
//
// Parameters
//   PC_WIDTH        program-counter and target width
//   IMEM_ADDR_WIDTH instruction-memory address width
//   RAS_DEPTH       return-address-stack entries (power of 2, >= 2)
//   RESET_PC        PC value after reset
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   halt, stall_req      current instruction is HALT / wants switch input
//   confirm              debounced confirm button level
//   branch, zero         conditional branch and ALU zero flag
//   jump, jr, jal        jump, jump-through-register, jump-and-link
//   imm, reg_target      sign-extended immediate; register jump operand
//   pc, pc_plus_one      current PC and pc+1 (combinational)
//   imem_addr            pc truncated to the instruction-memory width
//   advance              one-cycle pulse in the cycle after the PC updates
//   waiting, halted      high in WAIT_CONFIRM / HALTED
//   ras_count            number of valid RAS entries
//   ras_overflow         sticky: push while full
//   ras_underflow        sticky: pop while empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                     PC_WIDTH        = 32,
    parameter int                     IMEM_ADDR_WIDTH = 6,
    parameter int                     RAS_DEPTH       = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC        = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         halt,
    input  logic                         stall_req,
    input  logic                         confirm,
    input  logic                         branch,
    input  logic                         zero,
    input  logic                         jump,
    input  logic                         jr,
    input  logic                         jal,
    input  logic [PC_WIDTH-1:0]          imm,
    input  logic [PC_WIDTH-1:0]          reg_target,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [PC_WIDTH-1:0]          pc_plus_one,
    output logic [IMEM_ADDR_WIDTH-1:0]   imem_addr,
    output logic                         advance,
    output logic                         waiting,
    output logic                         halted,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    typedef enum logic [1:0] {
        RUN,
        WAIT_CONFIRM,
        HALTED
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PC_WIDTH-1:0]   pc_next;
    logic                  advance_next;
    logic                  confirm_q;
    logic                  confirm_rise;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [PC_WIDTH-1:0]   jr_target;
    logic                  do_push;
    logic                  do_pop;

    // All PC arithmetic wraps naturally at PC_WIDTH bits.
    assign pc_plus_one   = pc + PC_WIDTH'(1);
    assign branch_target = pc_plus_one + imm;
    assign imem_addr     = pc[IMEM_ADDR_WIDTH-1:0];
    assign waiting       = (state == WAIT_CONFIRM);
    assign halted        = (state == HALTED);

    // confirm_q follows confirm in every state. A button that is already held
    // at the moment we enter WAIT_CONFIRM therefore shows no edge.
    assign confirm_rise  = confirm & ~confirm_q;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        advance_next = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (stall_req) begin
                    state_next = WAIT_CONFIRM;
                end else begin
                    advance_next = 1'b1;
                    do_push      = jal;
                    if (branch && zero) begin
                        pc_next = branch_target;
                    end else if (jump && jr) begin
                        pc_next = jr_target;
                        do_pop  = 1'b1;
                    end else if (jump) begin
                        pc_next = imm;
                    end else begin
                        pc_next = pc_plus_one;
                    end
                end
            end
            WAIT_CONFIRM: begin
                if (confirm_rise) begin
                    pc_next      = pc_plus_one;
                    advance_next = 1'b1;
                    state_next   = RUN;
                end
            end
            HALTED: begin
                // Only reset leaves HALTED.
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            advance   <= 1'b0;
            confirm_q <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            advance   <= advance_next;
            confirm_q <= confirm;
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;      // next slot to write
    logic [PTR_W-1:0]    top_idx;      // most recent entry
    logic [CNT_W-1:0]    ras_cnt;
    logic                ras_empty;
    logic                ras_full;
    logic                pop_ok;
    logic                mem_we;
    logic [PTR_W-1:0]    mem_waddr;

    assign top_idx   = ras_ptr - PTR_W'(1);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == RAS_FULL);
    assign jr_target = ras_empty ? reg_target : ras_mem[top_idx];
    assign pop_ok    = do_pop & ~ras_empty;

    // When a pop and a push happen together, the push overwrites the entry
    // that was just popped. The pointer and count then stay the same. A plain
    // push at full writes at ras_ptr, which is the oldest slot, so the
    // circular buffer loses the oldest return address.
    assign mem_we    = do_push;
    assign mem_waddr = pop_ok ? top_idx : ras_ptr;

    // NOTE: the stack storage has no reset. Its contents are meaningless
    // while ras_cnt is 0, so only the pointer, the count and the flags reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ras_mem[mem_waddr] <= pc_plus_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (pop_ok && !do_push) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end else if (do_push && !pop_ok) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end
            if (do_pop && ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    assign ras_count = ras_cnt;
`else
    logic unused_ras;

    assign jr_target     = reg_target;
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
    assign unused_ras    = ^{jal, do_push, do_pop};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Each step drives the inputs and then pushes
// the expected post-edge outputs onto a scoreboard queue. After the clock edge
// the queue is drained and compared. The main instance is 32-bit with
// RAS_DEPTH=2. A second, 8-bit instance shares the stimulus and is compared
// only at the wrap-around point. The RAS expectations follow PC_SEQ_RAS_EN.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        halt, stall_req, confirm, branch, zero, jump, jr, jal;
    logic [31:0] imm, reg_target;

    logic [31:0] pc, pc_plus_one;
    logic [5:0]  imem_addr;
    logic        advance, waiting, halted;
    logic [1:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    logic [7:0]  pc8, pc8_p1;
    logic [5:0]  imem8;
    logic        adv8, wait8, halt8, ovf8, unf8;
    logic [3:0]  cnt8;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected RAS outputs, tracked by the bench as the stimulus unfolds.
    logic [1:0]  e_cnt;
    logic        e_ovf, e_unf;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        adv, wt, hl;
        logic [1:0]  cnt;
        logic        ovf, unf;
        logic        chk8;
        logic [7:0]  pc8;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(6), .RAS_DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .halt(halt), .stall_req(stall_req), .confirm(confirm),
        .branch(branch), .zero(zero), .jump(jump), .jr(jr), .jal(jal),
        .imm(imm), .reg_target(reg_target),
        .pc(pc), .pc_plus_one(pc_plus_one), .imem_addr(imem_addr), .advance(advance),
        .waiting(waiting), .halted(halted), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    pc_sequencer #(.PC_WIDTH(8), .IMEM_ADDR_WIDTH(6), .RAS_DEPTH(8), .RESET_PC(8'h0)) dut8 (
        .clk(clk), .reset(reset), .halt(halt), .stall_req(stall_req), .confirm(confirm),
        .branch(branch), .zero(zero), .jump(jump), .jr(jr), .jal(jal),
        .imm(imm[7:0]), .reg_target(reg_target[7:0]),
        .pc(pc8), .pc_plus_one(pc8_p1), .imem_addr(imem8), .advance(adv8),
        .waiting(wait8), .halted(halt8), .ras_count(cnt8),
        .ras_overflow(ovf8), .ras_underflow(unf8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] epc, input logic eadv,
                            input logic ewt, input logic ehl, input logic chk8,
                            input logic [7:0] epc8);
        exp_t e;
        e.tag  = tag;
        e.pc   = epc;
        e.adv  = eadv;
        e.wt   = ewt;
        e.hl   = ehl;
        e.cnt  = e_cnt;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        e.chk8 = chk8;
        e.pc8  = epc8;
        sb.push_back(e);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] epc, input logic eadv,
                              input logic ewt, input logic ehl);
        push_exp(tag, epc, eadv, ewt, ehl, 1'b0, 8'h00);
    endtask

    // Advance one clock and compare everything queued for this edge.
    task automatic tick();
        exp_t e;
        logic [31:0] e_p1;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            e_p1 = e.pc + 32'd1;
            check({e.tag, ".pc"},        pc,                   e.pc);
            check({e.tag, ".pc_plus1"},  pc_plus_one,          e_p1);
            check({e.tag, ".imem_addr"}, {26'd0, imem_addr},   {26'd0, e.pc[5:0]});
            check({e.tag, ".advance"},   {31'd0, advance},     {31'd0, e.adv});
            check({e.tag, ".waiting"},   {31'd0, waiting},     {31'd0, e.wt});
            check({e.tag, ".halted"},    {31'd0, halted},      {31'd0, e.hl});
            check({e.tag, ".ras_count"}, {30'd0, ras_count},   {30'd0, e.cnt});
            check({e.tag, ".ras_ovf"},   {31'd0, ras_overflow},  {31'd0, e.ovf});
            check({e.tag, ".ras_unf"},   {31'd0, ras_underflow}, {31'd0, e.unf});
            if (e.chk8) begin
                check({e.tag, ".pc8"},    {24'd0, pc8},    {24'd0, e.pc8});
                check({e.tag, ".pc8_p1"}, {24'd0, pc8_p1}, {24'd0, e.pc8 + 8'd1});
            end
        end
    endtask

    task automatic clr();
        halt = 0; stall_req = 0; confirm = 0; branch = 0; zero = 0;
        jump = 0; jr = 0; jal = 0; imm = 32'd0; reg_target = 32'd0;
    endtask

    task automatic clr_ras_exp();
        e_cnt = 2'd0; e_ovf = 1'b0; e_unf = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        clk = 0;
        reset = 0;
        clr();
        clr_ras_exp();

        // Reset state
        expect_out("reset_a", 32'd0, 0, 0, 0); tick();
        expect_out("reset_b", 32'd0, 0, 0, 0); tick();
        reset = 1;

        // Sequential stepping, pc 1..5
        for (int i = 1; i <= 5; i++) begin
            expect_out("seq", i, 1, 0, 0); tick();
        end

        // Stall with confirm already high: held level is not an edge
        stall_req = 1; confirm = 1;
        expect_out("stall_enter", 32'd5, 0, 1, 0); tick();
        stall_req = 0; halt = 1; jump = 1; imm = 32'h40;   // ignored while waiting
        expect_out("wait_level_high", 32'd5, 0, 1, 0); tick();
        confirm = 0;
        for (int i = 0; i < 3; i++) begin
            expect_out("wait_low", 32'd5, 0, 1, 0); tick();
        end
        confirm = 1;
        expect_out("confirm_edge", 32'd6, 1, 0, 0); tick();

        // Branch / jump
        clr(); jump = 1; imm = 32'd10;
        expect_out("jump_10", 32'd10, 1, 0, 0); tick();
        clr(); branch = 1; zero = 1; imm = 32'hFFFF_FFFC;
        expect_out("branch_taken", 32'd7, 1, 0, 0); tick();
        clr(); branch = 1; zero = 0; imm = 32'hFFFF_FFFC;
        expect_out("branch_not_taken", 32'd8, 1, 0, 0); tick();
        clr(); jump = 1; imm = 32'h20;
        expect_out("jump_abs", 32'h20, 1, 0, 0); tick();
        clr(); jump = 1; jr = 1; reg_target = 32'd3;
`ifdef PC_SEQ_RAS_EN
        e_unf = 1'b1;
`endif
        expect_out("jr_empty", 32'd3, 1, 0, 0); tick();
        clr(); branch = 1; zero = 1; jump = 1; imm = 32'd2;
        expect_out("branch_over_jump", 32'd6, 1, 0, 0); tick();

        // Halt has priority over stall; HALTED ignores everything but reset
        clr(); jump = 1; imm = 32'd9;
        expect_out("jump_9", 32'd9, 1, 0, 0); tick();
        clr(); halt = 1; stall_req = 1;
        expect_out("halt_enter", 32'd9, 0, 0, 1); tick();
        for (int i = 0; i < 10; i++) begin
            clr(); confirm = i[0]; stall_req = i[1]; jump = 1; imm = 32'h55;
            expect_out("halted_hold", 32'd9, 0, 0, 1); tick();
        end
        clr(); reset = 0; clr_ras_exp();
        expect_out("reset_from_halt", 32'd0, 0, 0, 0); tick();
        reset = 1;

        // Wrap-around on both widths
        jump = 1; imm = 32'hFFFF_FFFF;
        push_exp("jump_max", 32'hFFFF_FFFF, 1, 0, 0, 1'b1, 8'hFF); tick();
        clr();
        push_exp("wrap", 32'd0, 1, 0, 0, 1'b1, 8'h00); tick();

        // Reset in the middle of a wait
        expect_out("pre_wait", 32'd1, 1, 0, 0); tick();
        stall_req = 1;
        expect_out("wait_again", 32'd1, 0, 1, 0); tick();
        clr(); reset = 0;
        expect_out("reset_mid_wait", 32'd0, 0, 0, 0); tick();
        reset = 1;

        // Return-address stack: jal at pc 1, 4, 7, then three jr
        expect_out("ras_pc1", 32'd1, 1, 0, 0); tick();
        clr(); jump = 1; jal = 1; imm = 32'd4;
`ifdef PC_SEQ_RAS_EN
        e_cnt = 2'd1;
`endif
        expect_out("jal_1", 32'd4, 1, 0, 0); tick();
        imm = 32'd7;
`ifdef PC_SEQ_RAS_EN
        e_cnt = 2'd2;
`endif
        expect_out("jal_4", 32'd7, 1, 0, 0); tick();
        imm = 32'd20;
`ifdef PC_SEQ_RAS_EN
        e_ovf = 1'b1;
`endif
        expect_out("jal_7_overflow", 32'd20, 1, 0, 0); tick();
        clr(); jump = 1; jr = 1; reg_target = 32'h33;
        t = 32'h33;
`ifdef PC_SEQ_RAS_EN
        t = 32'd8; e_cnt = 2'd1;
`endif
        expect_out("jr_pop_1", t, 1, 0, 0); tick();
`ifdef PC_SEQ_RAS_EN
        t = 32'd5; e_cnt = 2'd0;
`endif
        expect_out("jr_pop_2", t, 1, 0, 0); tick();
`ifdef PC_SEQ_RAS_EN
        t = 32'h33; e_unf = 1'b1;
`endif
        expect_out("jr_pop_underflow", t, 1, 0, 0); tick();

        // jal & jr together: pop then push, count unchanged
        clr(); reset = 0; clr_ras_exp();
        expect_out("reset_ras", 32'd0, 0, 0, 0); tick();
        reset = 1; jump = 1; jal = 1; imm = 32'd3;
`ifdef PC_SEQ_RAS_EN
        e_cnt = 2'd1;
`endif
        expect_out("jal_0", 32'd3, 1, 0, 0); tick();
        clr(); jump = 1; jal = 1; jr = 1; reg_target = 32'h33;
        t = 32'h33;
`ifdef PC_SEQ_RAS_EN
        t = 32'd1;
`endif
        expect_out("jal_jr", t, 1, 0, 0); tick();
        clr(); jump = 1; jr = 1; reg_target = 32'h33;
        t = 32'h33;
`ifdef PC_SEQ_RAS_EN
        t = 32'd4; e_cnt = 2'd0;
`endif
        expect_out("jr_after_jal_jr", t, 1, 0, 0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
